// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
//
// Memory-access stage controller for the 8-bit pipelined MIPS datapath. It sits
// between EX_MEM and MEM_WB and runs one load or store at a time on an external
// data memory through a req/ack handshake. The upstream pipeline is stalled,
// and MEM_WB is bubbled, while a transaction is outstanding.
//
// Optional feature: define MEM_TIMEOUT_EN to abort a request after TIMEOUT
// cycles without dmem_ack. An aborted load returns 8'hFF, and the abort sets
// the sticky mem_error flag. Without the macro, REQ waits forever and
// mem_error is tied low.
//
// Parameters:
//   TIMEOUT           ack wait limit in cycles, 1..255 (MEM_TIMEOUT_EN only)
//
// Ports:
//   clk               pipeline clock; state updates on the rising edge
//   reset             asynchronous, active-low reset
//   EX_MEM_mem_read   load in the MEM stage
//   EX_MEM_mem_write  store in the MEM stage; wins if both are high
//   EX_MEM_alu_out    effective address
//   EX_MEM_store_data store data
//   dmem_req          memory request, held until ack
//   dmem_we           1 = write, 0 = read; valid while dmem_req is high
//   dmem_addr         latched address
//   dmem_wdata        latched store data
//   dmem_ack          memory completion; only looked at in REQ
//   dmem_rdata        read data; valid with dmem_ack on a read
//   mem_out_data      registered load result to MEM_WB
//   mem_stall         freezes PC, IF_ID, ID_EX and EX_MEM
//   mem_bubble        forces MEM_WB reg_write low
//   mem_error         sticky timeout flag
// -----------------------------------------------------------------------------
module mem_access_stage #(
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       EX_MEM_mem_read,
    input  logic       EX_MEM_mem_write,
    input  logic [7:0] EX_MEM_alu_out,
    input  logic [7:0] EX_MEM_store_data,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic [7:0] dmem_addr,
    output logic [7:0] dmem_wdata,
    input  logic       dmem_ack,
    input  logic [7:0] dmem_rdata,
    output logic [7:0] mem_out_data,
    output logic       mem_stall,
    output logic       mem_bubble,
    output logic       mem_error
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic       we_q,    we_d;
    logic [7:0] addr_q,  addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] out_q,   out_d;
    logic       op;
    logic       timeout_hit;

    assign op = EX_MEM_mem_read | EX_MEM_mem_write;

`ifdef MEM_TIMEOUT_EN
    // The counter value seen in the last REQ cycle that is still allowed to
    // wait. With TIMEOUT=N, REQ lasts at most N cycles.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    logic [7:0] cnt_q, cnt_d;
    logic       err_q, err_d;

    // An ack in the limit cycle takes priority over the abort.
    assign timeout_hit = (state_q == ST_REQ) && !dmem_ack && (cnt_q == TO_LAST);

    always_comb begin
        cnt_d = cnt_q;
        // REQ can only be entered from IDLE, so clearing in IDLE is the same
        // as clearing on REQ entry.
        if (state_q == ST_IDLE) begin
            cnt_d = 8'd0;
        end else if (state_q == ST_REQ && !dmem_ack) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_comb begin
        err_d = err_q | timeout_hit;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= 8'd0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign mem_error = err_q;
`else
    // TIMEOUT has no effect in this build; this keeps it referenced.
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT == 0);
    assign timeout_hit    = 1'b0;
    assign mem_error      = 1'b0;
`endif

    // Next-state and datapath-latch logic
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        out_d   = out_q;

        case (state_q)
            ST_IDLE: begin
                if (op) begin
                    addr_d  = EX_MEM_alu_out;
                    wdata_d = EX_MEM_store_data;
                    we_d    = EX_MEM_mem_write;   // store wins over load
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (dmem_ack) begin
                    if (!we_q) begin
                        out_d = dmem_rdata;
                    end
                    state_d = ST_DONE;
                end else if (timeout_hit) begin
                    if (!we_q) begin
                        out_d = 8'hFF;
                    end
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // EX_MEM still holds the completed instruction, so op is not
                // looked at here.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            addr_q  <= 8'h00;
            wdata_q <= 8'h00;
            out_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            out_q   <= out_d;
        end
    end

    // dmem_req is decoded from the state register, so an asynchronous reset
    // drops it at once and abandons the transaction.
    assign dmem_req     = (state_q == ST_REQ);
    assign dmem_we      = we_q;
    assign dmem_addr    = addr_q;
    assign dmem_wdata   = wdata_q;
    assign mem_out_data = out_q;

    assign mem_stall  = ((state_q == ST_IDLE) && op) || (state_q == ST_REQ);
    assign mem_bubble = mem_stall;

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

    logic       clk = 1'b0;
    logic       reset;
    logic       rd, wr;
    logic [7:0] alu_out, store_data;
    logic       dmem_req, dmem_we;
    logic [7:0] dmem_addr, dmem_wdata;
    logic       dmem_ack;
    logic [7:0] dmem_rdata;
    logic [7:0] mem_out_data;
    logic       mem_stall, mem_bubble, mem_error;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.TIMEOUT(4)) dut (
        .clk               (clk),
        .reset             (reset),
        .EX_MEM_mem_read   (rd),
        .EX_MEM_mem_write  (wr),
        .EX_MEM_alu_out    (alu_out),
        .EX_MEM_store_data (store_data),
        .dmem_req          (dmem_req),
        .dmem_we           (dmem_we),
        .dmem_addr         (dmem_addr),
        .dmem_wdata        (dmem_wdata),
        .dmem_ack          (dmem_ack),
        .dmem_rdata        (dmem_rdata),
        .mem_out_data      (mem_out_data),
        .mem_stall         (mem_stall),
        .mem_bubble        (mem_bubble),
        .mem_error         (mem_error)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Outputs are sampled on the falling edge.
    task automatic smp();
        @(negedge clk);
    endtask

    // Check the stall/bubble pair and the request line in one call.
    task automatic chk_ctl(input string tag, input logic stall, input logic req);
        chk({tag, "_stall"}, mem_stall, stall);
        chk({tag, "_bubble"}, mem_bubble, stall);
        chk({tag, "_req"}, dmem_req, req);
    endtask

    initial begin
        reset = 1'b0; rd = 1'b0; wr = 1'b0; alu_out = 8'h00; store_data = 8'h00;
        dmem_ack = 1'b0; dmem_rdata = 8'h00;

        // ---------------- reset ----------------
        tick(); tick();
        smp();
        chk_ctl("rst", 1'b0, 1'b0);
        chk("rst_we", dmem_we, 8'h00);
        chk("rst_addr", dmem_addr, 8'h00);
        chk("rst_wdata", dmem_wdata, 8'h00);
        chk("rst_out", mem_out_data, 8'h00);
        chk("rst_err", mem_error, 8'h00);
        tick();
        reset = 1'b1;
        smp();
        chk_ctl("rel", 1'b0, 1'b0);
        $display("txn reset: released");

        // ---------------- load, ack in 2nd REQ cycle ----------------
        tick();
        rd = 1'b1; alu_out = 8'h3C; dmem_rdata = 8'hA5;
        smp(); chk_ctl("ld_c0", 1'b1, 1'b0);
        tick();
        smp(); chk_ctl("ld_c1", 1'b1, 1'b1);
        chk("ld_c1_we", dmem_we, 8'h00);
        chk("ld_c1_addr", dmem_addr, 8'h3C);
        tick();
        dmem_ack = 1'b1;
        smp(); chk_ctl("ld_c2", 1'b1, 1'b1);
        chk("ld_c2_we", dmem_we, 8'h00);
        chk("ld_c2_addr", dmem_addr, 8'h3C);
        tick();
        dmem_ack = 1'b0; dmem_rdata = 8'h00;
        smp(); chk_ctl("ld_done", 1'b0, 1'b0);
        chk("ld_done_out", mem_out_data, 8'hA5);
        tick();
        rd = 1'b0;
        smp(); chk_ctl("ld_idle", 1'b0, 1'b0);
        chk("ld_idle_out", mem_out_data, 8'hA5);
        $display("txn load: addr=3c data=%02h", mem_out_data);

        // ------- store (read also high: store wins), same-cycle ack -------
        tick();
        rd = 1'b1; wr = 1'b1; alu_out = 8'h10; store_data = 8'h7E; dmem_rdata = 8'hC3;
        smp(); chk_ctl("st_c0", 1'b1, 1'b0);
        tick();
        dmem_ack = 1'b1;
        smp(); chk_ctl("st_c1", 1'b1, 1'b1);
        chk("st_we", dmem_we, 8'h01);
        chk("st_addr", dmem_addr, 8'h10);
        chk("st_wdata", dmem_wdata, 8'h7E);
        tick();
        dmem_ack = 1'b0;
        smp(); chk_ctl("st_done", 1'b0, 1'b0);
        chk("st_out_kept", mem_out_data, 8'hA5);
        tick();
        rd = 1'b0; wr = 1'b0;
        smp(); chk_ctl("st_idle", 1'b0, 1'b0);
        $display("txn store: addr=10 data=7e");

        // ---------------- back-to-back load then store ----------------
        tick();
        rd = 1'b1; alu_out = 8'h20; dmem_ack = 1'b1; dmem_rdata = 8'h99;  // ack in IDLE
        smp(); chk_ctl("bb_c0", 1'b1, 1'b0);
        chk("bb_c0_out", mem_out_data, 8'hA5);
        tick();
        dmem_rdata = 8'h5A;
        smp(); chk_ctl("bb_ld_req", 1'b1, 1'b1);
        chk("bb_ld_addr", dmem_addr, 8'h20);
        tick();
        dmem_rdata = 8'hEE;                                   // ack in DONE
        smp(); chk_ctl("bb_ld_done", 1'b0, 1'b0);
        chk("bb_ld_out", mem_out_data, 8'h5A);
        tick();
        rd = 1'b0; wr = 1'b1; alu_out = 8'h21; store_data = 8'h33;  // ack in IDLE
        smp(); chk_ctl("bb_st_c0", 1'b1, 1'b0);
        chk("bb_st_c0_out", mem_out_data, 8'h5A);
        tick();
        dmem_ack = 1'b0;
        smp(); chk_ctl("bb_st_req1", 1'b1, 1'b1);
        chk("bb_st_we", dmem_we, 8'h01);
        chk("bb_st_addr", dmem_addr, 8'h21);
        chk("bb_st_wdata", dmem_wdata, 8'h33);
        tick();
        dmem_ack = 1'b1;
        smp(); chk_ctl("bb_st_req2", 1'b1, 1'b1);
        tick();
        dmem_ack = 1'b0;
        smp(); chk_ctl("bb_st_done", 1'b0, 1'b0);
        chk("bb_st_out", mem_out_data, 8'h5A);
        tick();
        wr = 1'b0;
        smp(); chk_ctl("bb_idle", 1'b0, 1'b0);
        $display("txn back2back: load 20 -> %02h, store 21 <- 33", mem_out_data);

        // ---------------- reset in 2nd REQ cycle of a load ----------------
        tick();
        rd = 1'b1; alu_out = 8'h55; dmem_rdata = 8'h77;
        tick();                       // 1st REQ cycle
        smp(); chk_ctl("rq_req1", 1'b1, 1'b1);
        tick();                       // 2nd REQ cycle
        reset = 1'b0;
        #1;
        chk_ctl("rq_rst", 1'b1, 1'b0);  // IDLE with op still high
        chk("rq_out", mem_out_data, 8'h00);
        chk("rq_addr", dmem_addr, 8'h00);
        tick();
        rd = 1'b0;
        tick();
        reset = 1'b1;
        smp(); chk_ctl("rq_rel", 1'b0, 1'b0);
        chk("rq_err", mem_error, 8'h00);
        $display("txn reset_mid_req: abandoned");

`ifdef MEM_TIMEOUT_EN
        // ---------------- timeout, TIMEOUT=4, no ack ----------------
        tick();
        rd = 1'b1; alu_out = 8'h40;
        smp(); chk_ctl("to_c0", 1'b1, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            smp(); chk_ctl($sformatf("to_req%0d", i), 1'b1, 1'b1);
            chk($sformatf("to_req%0d_err", i), mem_error, 8'h00);
        end
        tick();
        smp(); chk_ctl("to_done", 1'b0, 1'b0);
        chk("to_out", mem_out_data, 8'hFF);
        chk("to_err", mem_error, 8'h01);
        tick();
        rd = 1'b0;
        smp(); chk_ctl("to_idle", 1'b0, 1'b0);
        $display("txn timeout: out=%02h err=%0d", mem_out_data, mem_error);

        // later successful load: error stays sticky
        tick();
        rd = 1'b1; alu_out = 8'h41; dmem_rdata = 8'h11;
        tick();
        dmem_ack = 1'b1;
        smp(); chk_ctl("to_ld_req", 1'b1, 1'b1);
        tick();
        dmem_ack = 1'b0;
        smp(); chk("to_ld_out", mem_out_data, 8'h11);
        chk("to_ld_err", mem_error, 8'h01);
        tick();
        rd = 1'b0;
        smp(); chk_ctl("to_ld_idle", 1'b0, 1'b0);
        $display("txn load_after_timeout: out=%02h err=%0d", mem_out_data, mem_error);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access stage controller for the 8-bit pipelined MIPS datapath. It sits between the EX_MEM and MEM_WB pipeline registers and performs load/store operations on an external data memory through a req/ack handshake. It produces the `mem_out_data` value that MEM_WB captures. While a transaction is outstanding it stalls the upstream pipeline and bubbles MEM_WB.

## Interface
Parameters:
- TIMEOUT, 15: maximum cycles spent waiting for `dmem_ack` before abort (only used with MEM_TIMEOUT_EN); range 1..255.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- EX_MEM_mem_read  in  1  load in MEM stage
- EX_MEM_mem_write  in  1  store in MEM stage
- EX_MEM_alu_out  in  8  effective address
- EX_MEM_store_data  in  8  store data
- dmem_req  out  1  memory request, held until ack
- dmem_we  out  1  1 = write, 0 = read; valid with dmem_req
- dmem_addr  out  8  latched address
- dmem_wdata  out  8  latched store data
- dmem_ack  in  1  memory completion; sampled only in REQ
- dmem_rdata  in  8  read data; valid when dmem_ack=1 and dmem_we=0
- mem_out_data  out  8  registered load result to MEM_WB
- mem_stall  out  1  freezes PC, IF_ID, ID_EX, EX_MEM
- mem_bubble  out  1  top level forces MEM_WB reg_write to 0 when high
- mem_error  out  1  sticky timeout flag

## Operation
- FSM states: IDLE, REQ, DONE.
- `op` = EX_MEM_mem_read | EX_MEM_mem_write.
- Store precedence: if both are high, the access is a store. No read data is captured.
- IDLE:
  - op=1: latch addr, wdata and we (= mem_write); go to REQ.
  - op=0: stay in IDLE.
- REQ:
  - dmem_req=1.
  - dmem_ack=1: if read, capture dmem_rdata into mem_out_data; go to DONE.
  - dmem_ack=0: stay in REQ.
- DONE:
  - Stall released for one cycle, so EX_MEM advances and MEM_WB captures the completed instruction.
  - op is ignored (it is still the same instruction); go to IDLE.
- mem_stall = (IDLE & op) | REQ. This is combinational.
- mem_bubble = mem_stall.
- mem_out_data changes only on a read ack or a timeout abort. Otherwise it holds its value; non-memory instructions do not disturb it.
- dmem_addr, dmem_wdata and dmem_we are registered and stable for the whole of REQ.
- dmem_ack outside REQ is ignored.

## Timing
- Reset values (applied asynchronously when reset=0):
  - state=IDLE
  - dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0
  - mem_out_data=8'h00
  - mem_error=0
  - mem_stall and mem_bubble follow the IDLE equation.
- Op visible in cycle 0:
  - cycle 0: IDLE, stall=1.
  - cycle 1: REQ, req=1.
  - ack in cycle k (k≥1): DONE in cycle k+1 with mem_out_data valid and stall=0.
  - MEM_WB captures at the end of cycle k+1.
- Minimum cost with same-cycle ack: 2 stall cycles per memory op.
- Back-to-back memory ops: the second op is seen in IDLE in cycle k+2 and a new transaction starts. There is no pipelining of requests.
- Reset mid-REQ: dmem_req drops immediately, the transaction is abandoned, and no data is captured.

## Configuration
- MEM_TIMEOUT_EN defined:
  - An 8-bit counter clears on REQ entry and increments each REQ cycle without ack.
  - When it reaches TIMEOUT with no ack: go to DONE, set mem_out_data=8'hFF (reads only), and set mem_error=1.
  - mem_error stays set until reset.
  - An ack in the same cycle the limit is reached wins: normal completion, no error.
- MEM_TIMEOUT_EN undefined:
  - No counter; REQ waits indefinitely.
  - mem_error is tied to 0.
  - TIMEOUT is unused.

## Test plan
- Reset: hold reset=0 with op=0 -> all outputs at their reset values. Release reset with op=0 -> stall=0.
- Load with ack 2 cycles after req, addr 8'h3C, rdata 8'hA5:
  - stall high for exactly 3 cycles;
  - dmem_we=0 and dmem_addr=8'h3C throughout REQ;
  - mem_out_data=8'hA5 in DONE, stall=0.
- Store, addr 8'h10, data 8'h7E, same-cycle ack:
  - req/we high for 1 cycle with wdata=8'h7E;
  - mem_out_data unchanged;
  - 2 stall cycles.
- Back-to-back load then store:
  - two separate REQ phases separated by DONE and IDLE;
  - ack pulses while the FSM is in DONE or IDLE are ignored.
- Reset asserted in the 2nd REQ cycle of a load -> dmem_req=0 immediately, FSM in IDLE, mem_out_data=8'h00.
- With MEM_TIMEOUT_EN, TIMEOUT=4, never ack:
  - REQ lasts 4 cycles, then DONE;
  - mem_out_data=8'hFF, mem_error=1;
  - mem_error stays 1 through a later successful load.
